// File: rtl/inverter_pkg.sv
// Shared mode encoding for the pipelined conditional inverter/negator.
package inverter_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_NEGATE = 2'b10,
    MODE_ABS    = 2'b11
  } mode_t;

  function automatic logic is_neg_mode(input mode_t m);
    return (m == MODE_NEGATE) || (m == MODE_ABS);
  endfunction

endpackage

// File: rtl/inv_pipe_reg.sv
// One pipeline slot: a valid bit plus a W-bit payload, advanced by a load enable.
module inv_pipe_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Occupancy follows the upstream valid whenever the slot is allowed to advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Payload only changes on a real item, so an empty slot keeps its last value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= {W{1'b0}};
    end else if (i_load && i_valid) begin
      r_data <= i_data;
    end else begin
      r_data <= r_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/inverter_pipe_nb.sv
// Two-stage pass/invert/negate/abs unit with valid/ready flow control.
module inverter_pipe_nb
  import inverter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NEG_EN = 1
) (
  input  logic             input_clk,
  input  logic             input_reset_n,
  input  logic [WIDTH-1:0] input_a,
  input  logic [1:0]       input_mode,
  input  logic             input_valid,
  output logic             output_ready,
  output logic [WIDTH-1:0] output_z,
  output logic             output_valid,
  input  logic             input_ready,
  output logic             output_overflow,
  output logic             output_zero
);

  localparam logic             NEG_ON   = (NEG_EN != 32'sd0);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mode_t            w_mode;
  logic             w_invert;
  logic             w_inc;
  logic             w_ovf;
  logic [WIDTH-1:0] w_inv;
  logic [WIDTH+1:0] w_s1_d;
  logic [WIDTH+1:0] w_s1_q;
  logic [WIDTH+1:0] w_s2_d;
  logic [WIDTH+1:0] w_s2_q;
  logic [WIDTH-1:0] w_sum;
  logic             w_s1_valid;
  logic             w_s2_valid;
  logic             w_s1_adv;
  logic             w_s2_adv;

  assign w_mode = mode_t'(input_mode);

  // Negation is split as invert-then-increment; the +1 is deferred to stage 2.
  always_comb begin
    w_inc    = 1'b0;
    w_invert = 1'b0;
    if (NEG_ON) begin
      case (w_mode)
        MODE_PASS: begin
          w_inc    = 1'b0;
          w_invert = 1'b0;
        end
        MODE_INVERT: begin
          w_inc    = 1'b0;
          w_invert = 1'b1;
        end
        MODE_NEGATE: begin
          w_inc    = 1'b1;
          w_invert = 1'b1;
        end
        MODE_ABS: begin
          w_inc    = input_a[WIDTH-1];
          w_invert = input_a[WIDTH-1];
        end
        default: begin
          w_inc    = 1'b0;
          w_invert = 1'b0;
        end
      endcase
    end else begin
      w_inc    = 1'b0;
      w_invert = (w_mode == MODE_INVERT) || is_neg_mode(w_mode);
    end
  end

  assign w_inv  = w_invert ? ~input_a : input_a;
  assign w_ovf  = w_inc && (input_a == MOST_NEG);
  assign w_s1_d = {w_inv, w_inc, w_ovf};

  assign w_s2_adv     = !w_s2_valid || input_ready;
  assign w_s1_adv     = !w_s1_valid || w_s2_adv;
  assign output_ready = w_s1_adv;

  inv_pipe_reg #(.W(WIDTH + 2)) u_s1 (
    .i_clk   (input_clk),
    .i_rst_n (input_reset_n),
    .i_load  (w_s1_adv),
    .i_valid (input_valid),
    .i_data  (w_s1_d),
    .o_valid (w_s1_valid),
    .o_data  (w_s1_q)
  );

  assign w_sum  = w_s1_q[WIDTH+1:2] + {{(WIDTH-1){1'b0}}, w_s1_q[1]};
  assign w_s2_d = {w_sum, w_s1_q[0], (w_sum == {WIDTH{1'b0}})};

  inv_pipe_reg #(.W(WIDTH + 2)) u_s2 (
    .i_clk   (input_clk),
    .i_rst_n (input_reset_n),
    .i_load  (w_s2_adv),
    .i_valid (w_s1_valid),
    .i_data  (w_s2_d),
    .o_valid (w_s2_valid),
    .o_data  (w_s2_q)
  );

  assign output_valid    = w_s2_valid;
  assign output_z        = w_s2_q[WIDTH+1:2];
  assign output_overflow = w_s2_q[1];
  assign output_zero     = w_s2_q[0];

endmodule
